// File: rtl/bitwise_unit_arbiter_if.sv
// Requester, datapath and completion signals shared by bitwise_unit_arbiter and its environment.
// slave is the arbiter's view; master is the environment (requesters plus structural datapath).
interface bitwise_unit_arbiter_if;
    logic        req0;
    logic [1:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        req1;
    logic [1:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic [1:0]  dp_op;
    logic [31:0] dp_res;
    logic [31:0] result;
    logic        done0;
    logic        done1;
    logic        busy;
    logic        gnt_id;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, dp_res,
        output dp_a, dp_b, dp_op, result, done0, done1, busy, gnt_id
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, dp_res,
        input  dp_a, dp_b, dp_op, result, done0, done1, busy, gnt_id
    );
endinterface

// File: rtl/bitwise_unit_arbiter.sv
// Round-robin sharing of one external gate-level bitwise unit between two requesters,
// holding registered operands for SETTLE_CYCLES edges before capturing the result.
module bitwise_unit_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    bitwise_unit_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state, state_nx;
    logic [31:0]       dp_a_q, dp_a_nx;
    logic [31:0]       dp_b_q, dp_b_nx;
    logic [1:0]        dp_op_q, dp_op_nx;
    logic [31:0]       result_q, result_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              done0_q, done0_nx;
    logic              done1_q, done1_nx;
    logic              busy_q, busy_nx;
    logic              gnt_q, gnt_nx;
    logic              any_req;
    logic              win_id;

    // On a tie the requester that was not granted last wins; a lone request always wins.
    assign any_req = bus.req0 | bus.req1;
    assign win_id  = (bus.req0 & bus.req1) ? ~gnt_q : bus.req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dp_a_q   <= '0;
            dp_b_q   <= '0;
            dp_op_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            gnt_q    <= 1'b1;
        end else begin
            state    <= state_nx;
            dp_a_q   <= dp_a_nx;
            dp_b_q   <= dp_b_nx;
            dp_op_q  <= dp_op_nx;
            result_q <= result_nx;
            cnt_q    <= cnt_nx;
            done0_q  <= done0_nx;
            done1_q  <= done1_nx;
            busy_q   <= busy_nx;
            gnt_q    <= gnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dp_a_nx   = dp_a_q;
        dp_b_nx   = dp_b_q;
        dp_op_nx  = dp_op_q;
        result_nx = result_q;
        cnt_nx    = cnt_q;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        busy_nx   = busy_q;
        gnt_nx    = gnt_q;

        case (state)
            IDLE: begin
                if (any_req) begin
                    dp_a_nx  = win_id ? bus.a1  : bus.a0;
                    dp_b_nx  = win_id ? bus.b1  : bus.b0;
                    dp_op_nx = win_id ? bus.op1 : bus.op0;
                    gnt_nx   = win_id;
                    cnt_nx   = CNT_LOAD;
                    busy_nx  = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    result_nx = bus.dp_res;
                    done0_nx  = ~gnt_q;
                    done1_nx  = gnt_q;
                    state_nx  = DONE;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Requests are not looked at here so a requester dropping req on done is not re-served.
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.dp_a   = dp_a_q;
    assign bus.dp_b   = dp_b_q;
    assign bus.dp_op  = dp_op_q;
    assign bus.result = result_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = gnt_q;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed bench for bitwise_unit_arbiter: one nominal instance plus two instances driving a slow datapath.
module tb_bitwise_unit_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bitwise_unit_arbiter_if bus_m ();
    bitwise_unit_arbiter_if bus_s1 ();
    bitwise_unit_arbiter_if bus_s3 ();

    function automatic logic [31:0] bw(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Gate-chain models: fast enough for the nominal instance, slower than one clock for the others.
    assign #3  bus_m.dp_res  = bw(bus_m.dp_op,  bus_m.dp_a,  bus_m.dp_b);
    assign #15 bus_s1.dp_res = bw(bus_s1.dp_op, bus_s1.dp_a, bus_s1.dp_b);
    assign #15 bus_s3.dp_res = bw(bus_s3.dp_op, bus_s3.dp_a, bus_s3.dp_b);

    bitwise_unit_arbiter #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus_m));
    bitwise_unit_arbiter #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_s1 (.clk(clk), .reset(reset), .bus(bus_s1));
    bitwise_unit_arbiter #(.SETTLE_CYCLES(3), .CNT_W(8)) dut_s3 (.clk(clk), .reset(reset), .bus(bus_s3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus_m.done0 || bus_m.done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   id;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_m.req0 = 0; bus_m.op0 = 0; bus_m.a0 = 0; bus_m.b0 = 0;
        bus_m.req1 = 0; bus_m.op1 = 0; bus_m.a1 = 0; bus_m.b1 = 0;
        bus_s1.req0 = 0; bus_s1.op0 = 0; bus_s1.a0 = 0; bus_s1.b0 = 0;
        bus_s1.req1 = 0; bus_s1.op1 = 0; bus_s1.a1 = 0; bus_s1.b1 = 0;
        bus_s3.req0 = 0; bus_s3.op0 = 0; bus_s3.a0 = 0; bus_s3.b0 = 0;
        bus_s3.req1 = 0; bus_s3.op1 = 0; bus_s3.a1 = 0; bus_s3.b1 = 0;
        repeat (2) step();

        chk("rst_dp_a",   bus_m.dp_a,   32'h0);
        chk("rst_dp_b",   bus_m.dp_b,   32'h0);
        chk("rst_dp_op",  bus_m.dp_op,  32'h0);
        chk("rst_result", bus_m.result, 32'h0);
        chk("rst_done0",  bus_m.done0,  32'h0);
        chk("rst_done1",  bus_m.done1,  32'h0);
        chk("rst_busy",   bus_m.busy,   32'h0);
        chk("rst_gnt",    bus_m.gnt_id, 32'h1);

        // NOT with SETTLE_CYCLES=2
        reset = 1'b0;
        bus_m.req0 = 1; bus_m.op0 = 2'b00; bus_m.a0 = 32'h0F0F0F0F;
        step();
        chk("not_dp_a",   bus_m.dp_a,   32'h0F0F0F0F);
        chk("not_gnt",    bus_m.gnt_id, 32'h0);
        chk("not_busy",   bus_m.busy,   32'h1);
        chk("not_early1", bus_m.done0,  32'h0);
        step();
        chk("not_early2", bus_m.done0,  32'h0);
        step();
        chk("not_done0",  bus_m.done0,  32'h1);
        chk("not_result", bus_m.result, 32'hF0F0F0F0);
        chk("not_done1",  bus_m.done1,  32'h0);
        bus_m.req0 = 0;
        step();
        chk("not_pulse",  bus_m.done0,  32'h0);
        chk("not_idle",   bus_m.busy,   32'h0);

        // Reset between edges while settling
        bus_m.req0 = 1; bus_m.op0 = 2'b01; bus_m.a0 = 32'hFFFFFFFF; bus_m.b0 = 32'h12345678;
        step();
        chk("abort_busy_pre", bus_m.busy, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("abort_dp_a",   bus_m.dp_a,   32'h0);
        chk("abort_busy",   bus_m.busy,   32'h0);
        chk("abort_gnt",    bus_m.gnt_id, 32'h1);
        chk("abort_result", bus_m.result, 32'h0);
        chk("abort_done0",  bus_m.done0,  32'h0);
        bus_m.req0 = 0;
        step();
        step();
        chk("abort_nodone", bus_m.done0,  32'h0);
        reset = 1'b0;
        bus_m.req0 = 1; bus_m.op0 = 2'b00; bus_m.a0 = 32'h0000FFFF;
        step();
        chk("rearm_gnt",  bus_m.gnt_id, 32'h0);
        chk("rearm_dp_a", bus_m.dp_a,   32'h0000FFFF);
        chk("rearm_busy", bus_m.busy,   32'h1);
        step();
        step();
        chk("rearm_done0",  bus_m.done0,  32'h1);
        chk("rearm_result", bus_m.result, 32'hFFFF0000);
        bus_m.req0 = 0;
        step();

        // Simultaneous requests after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_m.req0 = 1; bus_m.op0 = 2'b10; bus_m.a0 = 32'h12345678; bus_m.b0 = 32'h0000FFFF;
        bus_m.req1 = 1; bus_m.op1 = 2'b11; bus_m.a1 = 32'hFFFF0000; bus_m.b1 = 32'hFF00FF00;
        step();
        chk("tie_gnt0",  bus_m.gnt_id, 32'h0);
        chk("tie_op0",   bus_m.dp_op,  32'h2);
        step();
        step();
        chk("tie_done0", bus_m.done0,  32'h1);
        chk("tie_res0",  bus_m.result, 32'h1234FFFF);
        chk("tie_nd1",   bus_m.done1,  32'h0);
        bus_m.req0 = 0;
        step();
        chk("tie_gap_busy", bus_m.busy,   32'h0);
        chk("tie_gap_gnt",  bus_m.gnt_id, 32'h0);
        step();
        chk("tie_gnt1",  bus_m.gnt_id, 32'h1);
        chk("tie_op1",   bus_m.dp_op,  32'h3);
        chk("tie_a1",    bus_m.dp_a,   32'hFFFF0000);
        step();
        step();
        chk("tie_done1", bus_m.done1,  32'h1);
        chk("tie_res1",  bus_m.result, 32'h00FFFF00);
        chk("tie_nd0",   bus_m.done0,  32'h0);
        bus_m.req1 = 0;
        step();

        // Both requesters hold req for six operations
        bus_m.op0 = 2'b00; bus_m.a0 = 32'hAAAA5555; bus_m.b0 = 32'h0;
        bus_m.op1 = 2'b01; bus_m.a1 = 32'hF0F0F0F0; bus_m.b1 = 32'hFF00FF00;
        bus_m.req0 = 1; bus_m.req1 = 1;
        for (int i = 0; i < 6; i++) begin
            id = i % 2;
            wait_done(12, ok);
            chk("rr_wait", ok, 32'h1);
            chk("rr_gnt",   bus_m.gnt_id, id);
            chk("rr_done0", bus_m.done0,  (id == 0) ? 32'h1 : 32'h0);
            chk("rr_done1", bus_m.done1,  (id == 1) ? 32'h1 : 32'h0);
            chk("rr_res",   bus_m.result, (id == 0) ? 32'h5555AAAA : 32'hF000F000);
            if (i == 5) begin
                bus_m.req0 = 0;
                bus_m.req1 = 0;
            end
            step();
            chk("rr_pulse", {bus_m.done1, bus_m.done0}, 32'h0);
        end
        step();
        chk("rr_quiet", bus_m.busy, 32'h0);

        // Operand change after grant
        bus_m.req0 = 1; bus_m.op0 = 2'b01; bus_m.a0 = 32'h0F0F0F0F; bus_m.b0 = 32'h00FF00FF;
        step();
        chk("hold_dp_a1", bus_m.dp_a, 32'h0F0F0F0F);
        bus_m.a0 = 32'hDEADBEEF;
        step();
        chk("hold_dp_a2", bus_m.dp_a, 32'h0F0F0F0F);
        step();
        chk("hold_done0",  bus_m.done0,  32'h1);
        chk("hold_result", bus_m.result, 32'h000F000F);
        bus_m.req0 = 0;
        step();

        // Undersized settle window versus a slow datapath
        bus_s1.req0 = 1; bus_s1.op0 = 2'b01; bus_s1.a0 = 32'h12345678; bus_s1.b0 = 32'hFF00FF00;
        bus_s3.req0 = 1; bus_s3.op0 = 2'b01; bus_s3.a0 = 32'h12345678; bus_s3.b0 = 32'hFF00FF00;
        step();
        step();
        chk("s1_done0", bus_s1.done0,  32'h1);
        chk("s1_stale", bus_s1.result, 32'hFFFFFFFF);
        if (bus_s1.result !== 32'h12005600)
            $display("note: SETTLE_CYCLES=1 captured %h, datapath delay exceeds the settle window", bus_s1.result);
        bus_s1.req0 = 0;
        step();
        chk("s3_early", bus_s3.done0, 32'h0);
        step();
        chk("s3_done0",  bus_s3.done0,  32'h1);
        chk("s3_result", bus_s3.result, 32'h12005600);
        bus_s3.req0 = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
